// File: rtl/instr_fetch_buffer_pkg.sv
// Shared fetch-stage definitions: window geometry, FSM encoding and the
// rule for how many memory words an instruction window spans.
package instr_fetch_buffer_pkg;

    localparam int IBYTES     = 10;
    localparam int WORD_BYTES = 8;
    localparam int WORD_W     = WORD_BYTES * 8;
    localparam int MAX_WORDS  = 3;
    localparam int WIN_W      = IBYTES * 8;
    localparam int BUF_W      = MAX_WORDS * WORD_W;
    localparam int OFF_W      = $clog2(WORD_BYTES);

    // Only an offset of 7 pushes byte 9 into a third word.
    localparam logic [OFF_W-1:0] SPAN3_OFF = OFF_W'(7);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DONE  = 2'd2
    } fetch_state_t;

    function automatic logic [1:0] words_needed(input logic [OFF_W-1:0] off);
        return (off == SPAN3_OFF) ? 2'd3 : 2'd2;
    endfunction

endpackage

// File: rtl/instr_byte_aligner.sv
// Extracts the IBYTES-byte little-endian window starting at byte `off`
// of a MAX_WORDS-word buffer. Purely combinational.
module instr_byte_aligner
    import instr_fetch_buffer_pkg::*;
(
    input  logic [BUF_W-1:0]  buf_words,
    input  logic [OFF_W-1:0]  off,
    output logic [WIN_W-1:0]  window
);

    assign window = buf_words[{off, 3'b000} +: WIN_W];

endmodule

// File: rtl/instr_fetch_buffer.sv
// Fetch front end: reads the aligned words covering the instruction at pc,
// then presents an aligned 80-bit window with valid/error flags.
module instr_fetch_buffer
    import instr_fetch_buffer_pkg::*;
#(
    parameter int ADDR_W = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [ADDR_W-1:0]  pc,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [WORD_W-1:0]  mem_rdata,
    input  logic               mem_ack,
    input  logic               mem_err,
    output logic               busy,
    output logic               instr_valid,
    output logic               instr_error,
    output logic [WIN_W-1:0]   instruction,
    output fetch_state_t       dbg_state
);

    localparam int BASE_W = ADDR_W - OFF_W;

    fetch_state_t                     state;
    logic [BASE_W-1:0]                base;
    logic [OFF_W-1:0]                 off;
    logic [1:0]                       idx;
    logic [1:0]                       nwords;
    logic [MAX_WORDS-1:0][WORD_W-1:0] word_buf;
    logic                             load_win;
    logic                             err_seen;
    logic [WIN_W-1:0]                 window;

    // Handshake: mem_req stays high with a stable mem_addr until mem_ack is
    // seen on a rising edge; that edge consumes one word (same-cycle ack ok).
    assign mem_req   = (state == ST_FETCH);
    assign mem_addr  = {base + BASE_W'(idx), {OFF_W{1'b0}}};
    assign dbg_state = state;

    instr_byte_aligner u_aligner (
        .buf_words (word_buf),
        .off       (off),
        .window    (window)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            base        <= '0;
            off         <= '0;
            idx         <= '0;
            nwords      <= '0;
            word_buf    <= '0;
            load_win    <= 1'b0;
            err_seen    <= 1'b0;
            busy        <= 1'b0;
            instr_valid <= 1'b0;
            instr_error <= 1'b0;
            instruction <= '0;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (mem_ack) begin
                        word_buf[idx] <= mem_rdata;
                        if (mem_err || (idx == nwords - 2'd1)) begin
                            err_seen <= mem_err;
                            load_win <= 1'b1;
                            busy     <= 1'b0;
                            state    <= ST_DONE;
                        end else begin
                            idx <= idx + 2'd1;
                        end
                    end
                end
                default: begin
                    if (start) begin
                        base        <= pc[ADDR_W-1:OFF_W];
                        off         <= pc[OFF_W-1:0];
                        nwords      <= words_needed(pc[OFF_W-1:0]);
                        idx         <= '0;
                        word_buf    <= '0;
                        load_win    <= 1'b0;
                        err_seen    <= 1'b0;
                        instr_valid <= 1'b0;
                        instr_error <= 1'b0;
                        busy        <= 1'b1;
                        state       <= ST_FETCH;
                    end else if (load_win) begin
                        // Window is taken from the settled buffer one cycle after the last word.
                        instruction <= window;
                        instr_valid <= 1'b1;
                        instr_error <= err_seen;
                        load_win    <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Bench for instr_fetch_buffer: byte-addressed memory responder, reference
// window model, expected-response queue and a decoupled output monitor.
module tb_instr_fetch_buffer;
    import instr_fetch_buffer_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [63:0]  pc;
    logic         mem_req;
    logic [63:0]  mem_addr;
    logic [63:0]  mem_rdata;
    logic         mem_ack;
    logic         mem_err;
    logic         busy;
    logic         instr_valid;
    logic         instr_error;
    logic [79:0]  instruction;
    fetch_state_t dbg_state;

    int checks = 0;
    int errors = 0;

    logic [63:0] addr_q[$];
    logic [80:0] exp_q[$];

    int       cfg_waits = 0;
    int       cfg_err   = 9;
    int       word_no   = 0;
    bit       junk_en   = 1'b0;
    logic [7:0] key     = 8'h00;

    instr_fetch_buffer #(.ADDR_W(64)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .pc          (pc),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .mem_err     (mem_err),
        .busy        (busy),
        .instr_valid (instr_valid),
        .instr_error (instr_error),
        .instruction (instruction),
        .dbg_state   (dbg_state)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] byte_at(input logic [63:0] a);
        return a[7:0] ^ key;
    endfunction

    function automatic logic [63:0] mem_word(input logic [63:0] a);
        logic [63:0] w;
        for (int i = 0; i < 8; i++) w[8*i +: 8] = byte_at(a + 64'(i));
        return w;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory responder: drives ack/data on the falling edge, checks request addresses.
    initial begin
        int wcnt;
        wcnt      = 0;
        mem_ack   = 1'b0;
        mem_err   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                wcnt    = 0;
                mem_ack = 1'b0;
                mem_err = 1'b0;
            end else if (mem_req) begin
                if (wcnt < cfg_waits) begin
                    wcnt++;
                    mem_ack   = 1'b0;
                    mem_err   = 1'($urandom_range(0, 1));
                    mem_rdata = {$urandom, $urandom};
                end else begin
                    wcnt    = 0;
                    mem_ack = 1'b1;
                    mem_err = (word_no == cfg_err);
                    mem_rdata = mem_err ? 64'h0 : mem_word(mem_addr);
                    word_no++;
                    if (addr_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_req: got addr %h expected no request", mem_addr);
                    end else begin
                        check("req_addr", mem_addr, addr_q.pop_front());
                    end
                end
            end else begin
                wcnt      = 0;
                mem_ack   = junk_en ? 1'($urandom_range(0, 1)) : 1'b0;
                mem_err   = 1'($urandom_range(0, 1));
                mem_rdata = {$urandom, $urandom};
            end
        end
    end

    // Output monitor: each new completed window is compared with the oldest expectation.
    initial begin
        logic prev_v;
        logic [80:0] e;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && instr_valid && !prev_v) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL window_unexpected: got %h expected none", {instr_error, instruction});
                end else begin
                    e = exp_q.pop_front();
                    check("instr_error", instr_error, e[80]);
                    check("instruction", instruction, e[79:0]);
                end
            end
            prev_v = instr_valid;
        end
    end

    task automatic do_fetch(input logic [63:0] p, input int waits, input int err_w);
        int nw, last, lat_exp, cyc, j;
        logic [79:0] win;
        nw   = (p[2:0] == 3'd7) ? 3 : 2;
        last = (err_w < nw) ? err_w : nw - 1;
        for (int w = 0; w <= last; w++) addr_q.push_back(((p >> 3) + 64'(w)) << 3);
        for (int k = 0; k < 10; k++) begin
            j = (int'(p[2:0]) + k) / 8;
            win[8*k +: 8] = (j < last || (j == last && err_w >= nw)) ? byte_at(p + 64'(k)) : 8'h00;
        end
        exp_q.push_back({(err_w < nw), win});
        lat_exp = 1 + (last + 1) * (1 + waits);

        @(negedge clk);
        cfg_waits = waits;
        cfg_err   = err_w;
        word_no   = 0;
        pc        = p;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        pc    = {$urandom, $urandom};
        check("valid_drop", instr_valid, 1'b0);
        check("busy_fetch", busy, 1'b1);
        cyc = 0;
        while (!instr_valid && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("latency", cyc, lat_exp);
        check("busy_done", busy, 1'b0);
        check("req_count_left", addr_q.size(), 0);
        addr_q.delete();
    endtask

    task automatic reset_mid_fetch();
        key = 8'h00;
        addr_q.push_back(64'h20);
        addr_q.push_back(64'h28);
        @(negedge clk);
        cfg_waits = 1;
        cfg_err   = 9;
        word_no   = 0;
        pc        = 64'h20;
        start     = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b1;
        pc    = 64'h100;
        @(posedge clk);
        #1 start = 1'b0;
        check("poke_state", dbg_state, ST_FETCH);
        check("poke_addr", mem_addr, 64'h28);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_addr", mem_addr, 64'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_valid", instr_valid, 1'b0);
        check("rst_error", instr_error, 1'b0);
        check("rst_instr", instruction, 80'h0);
        check("rst_state", dbg_state, ST_IDLE);
        addr_q.delete();
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
    endtask

    initial begin
        logic [63:0] rp;
        int rerr;
        rst_n = 1'b1;
        start = 1'b0;
        pc    = '0;
        #2 rst_n = 1'b0;
        #1;
        check("init_mem_req", mem_req, 1'b0);
        check("init_mem_addr", mem_addr, 64'h0);
        check("init_busy", busy, 1'b0);
        check("init_valid", instr_valid, 1'b0);
        check("init_error", instr_error, 1'b0);
        check("init_instr", instruction, 80'h0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        do_fetch(64'h0, 0, 9);
        check("pc0_window", instruction, 80'h09080706050403020100);
        do_fetch(64'h7, 0, 9);
        check("pc7_window", instruction, 80'h100F0E0D0C0B0A090807);
        do_fetch(64'h13, 2, 9);
        check("pc13_window", instruction, 80'h1C1B1A19181716151413);

        reset_mid_fetch();
        do_fetch(64'h3, 0, 9);
        check("pc3_window", instruction, 80'h0C0B0A09080706050403);

        do_fetch(64'h8, 0, 0);
        check("err_flag", instr_error, 1'b1);
        check("err_window", instruction, 80'h0);
        do_fetch(64'hFFFF_FFFF_FFFF_FFFF, 0, 9);
        check("wrap_window", instruction, 80'h080706050403020100FF);

        junk_en = 1'b1;
        for (int n = 0; n < 24; n++) begin
            rp   = {$urandom, $urandom};
            rerr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : 9;
            key  = 8'($urandom);
            do_fetch(rp, int'($urandom_range(0, 2)), rerr);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        junk_en = 1'b0;

        repeat (4) @(posedge clk);
        #1;
        check("exp_q_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
